// File: rtl/dram_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : dram_ctrl_if
//  Description : Bundle between the MEM-stage data port, the data-memory
//                controller and the external asynchronous SRAM.
//                master = MEM stage plus SRAM environment, slave = controller.
//  Revision    : 1.0 - initial release
// ============================================================================
interface dram_ctrl_if #(
    parameter int SRAM_AW = 20
);
    // MEM-stage request side
    logic [31:0]        mem_dram_o_addr;
    logic [31:0]        mem_dram_o_data;
    logic               dram_en_n;
    logic               dram_we_n;
    logic               dram_re_n;
    logic [3:0]         mem_sel;
    logic [31:0]        dram_o_data;
    logic               dram_stall;

    // SRAM side
    logic [SRAM_AW-1:0] sram_addr;
    logic [31:0]        sram_dq_o;
    logic               sram_dq_oe;
    logic [31:0]        sram_dq_i;
    logic               sram_ce_n;
    logic               sram_oe_n;
    logic               sram_we_n;
    logic [3:0]         sram_be_n;

    modport master (
        output mem_dram_o_addr, mem_dram_o_data, dram_en_n, dram_we_n,
               dram_re_n, mem_sel, sram_dq_i,
        input  dram_o_data, dram_stall, sram_addr, sram_dq_o, sram_dq_oe,
               sram_ce_n, sram_oe_n, sram_we_n, sram_be_n
    );

    modport slave (
        input  mem_dram_o_addr, mem_dram_o_data, dram_en_n, dram_we_n,
               dram_re_n, mem_sel, sram_dq_i,
        output dram_o_data, dram_stall, sram_addr, sram_dq_o, sram_dq_oe,
               sram_ce_n, sram_oe_n, sram_we_n, sram_be_n
    );
endinterface
`default_nettype wire

// File: rtl/dram_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : dram_ctrl
//  Description : Data-memory responder for the MEM stage. Runs one registered
//                multi-cycle access on an asynchronous 32-bit SRAM per request
//                and stalls the pipeline until the access completes.
//  Revision    : 1.0 - initial release
// ============================================================================
module dram_ctrl #(
    parameter int SRAM_AW     = 20,
    parameter int WAIT_CYCLES = 1
) (
    input  wire logic     clk,
    input  wire logic     rst_n,
    dram_ctrl_if.slave    bus
);

    localparam int                 c_CNT_W    = $clog2(WAIT_CYCLES + 1);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(WAIT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_RD       = 3'd1,
        S_WR_SETUP = 3'd2,
        S_WR_PULSE = 3'd3,
        S_WR_HOLD  = 3'd4,
        S_DONE     = 3'd5
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [c_CNT_W-1:0]   r_cnt;

    // Request captured when leaving IDLE
    logic [SRAM_AW-1:0]   r_addr;
    logic [31:0]          r_data;
    logic [3:0]           r_sel;

    // Registered outputs
    logic [SRAM_AW-1:0]   r_sram_addr;
    logic [31:0]          r_sram_dq_o;
    logic                 r_sram_dq_oe;
    logic                 r_sram_ce_n;
    logic                 r_sram_oe_n;
    logic                 r_sram_we_n;
    logic [3:0]           r_sram_be_n;
    logic [31:0]          r_dram_o_data;

    logic                 w_wr_req;
    logic                 w_rd_req;
    logic                 w_req;
    logic                 w_cnt_done;
    logic [SRAM_AW-1:0]   w_addr_src;
    logic [31:0]          w_data_src;
    logic [3:0]           w_sel_src;
    logic                 w_unused;

    // Write wins when both strobes are low
    assign w_wr_req   = !bus.dram_en_n && !bus.dram_we_n;
    assign w_rd_req   = !bus.dram_en_n &&  bus.dram_we_n && !bus.dram_re_n;
    assign w_req      = w_wr_req || w_rd_req;
    assign w_cnt_done = (r_cnt == c_CNT_LAST);

    // In IDLE the SRAM outputs for the first access cycle must come straight
    // from the request, since the latches load on that same edge.
    assign w_addr_src = (r_state == S_IDLE) ? bus.mem_dram_o_addr[SRAM_AW+1:2] : r_addr;
    assign w_data_src = (r_state == S_IDLE) ? bus.mem_dram_o_data : r_data;
    assign w_sel_src  = (r_state == S_IDLE) ? bus.mem_sel : r_sel;

    // Byte-offset and out-of-range address bits are not used by a word SRAM
    assign w_unused = ^{bus.mem_dram_o_addr[31:SRAM_AW+2], bus.mem_dram_o_addr[1:0]};

    // Next-state decode
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_wr_req) begin
                    w_state_nxt = S_WR_SETUP;
                end else if (w_rd_req) begin
                    w_state_nxt = S_RD;
                end
            end
            S_RD:       if (w_cnt_done) w_state_nxt = S_DONE;
            S_WR_SETUP: w_state_nxt = S_WR_PULSE;
            S_WR_PULSE: if (w_cnt_done) w_state_nxt = S_WR_HOLD;
            S_WR_HOLD:  w_state_nxt = S_DONE;
            S_DONE:     w_state_nxt = S_IDLE;
            default:    w_state_nxt = S_IDLE;
        endcase
    end

    // State, wait counter, request latches and SRAM outputs keyed on next state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_cnt         <= '0;
            r_addr        <= '0;
            r_data        <= '0;
            r_sel         <= 4'hF;
            r_sram_addr   <= '0;
            r_sram_dq_o   <= '0;
            r_sram_dq_oe  <= 1'b0;
            r_sram_ce_n   <= 1'b1;
            r_sram_oe_n   <= 1'b1;
            r_sram_we_n   <= 1'b1;
            r_sram_be_n   <= 4'hF;
            r_dram_o_data <= '0;
        end else begin
            r_state <= w_state_nxt;

            if ((w_state_nxt == S_RD && r_state != S_RD) ||
                (w_state_nxt == S_WR_PULSE && r_state != S_WR_PULSE)) begin
                r_cnt <= '0;
            end else if (r_state == S_RD || r_state == S_WR_PULSE) begin
                r_cnt <= r_cnt + 1'b1;
            end

            if (r_state == S_IDLE && w_req) begin
                r_addr <= bus.mem_dram_o_addr[SRAM_AW+1:2];
                r_data <= bus.mem_dram_o_data;
                r_sel  <= bus.mem_sel;
            end

            // Load data is captured on the edge that leaves RD
            if (r_state == S_RD && w_cnt_done) begin
                r_dram_o_data <= bus.sram_dq_i;
            end

            case (w_state_nxt)
                S_RD: begin
                    r_sram_addr  <= w_addr_src;
                    r_sram_ce_n  <= 1'b0;
                    r_sram_oe_n  <= 1'b0;
                    r_sram_we_n  <= 1'b1;
                    r_sram_be_n  <= 4'b0000;
                    r_sram_dq_oe <= 1'b0;
                end
                S_WR_SETUP, S_WR_HOLD, S_WR_PULSE: begin
                    r_sram_addr  <= w_addr_src;
                    r_sram_ce_n  <= 1'b0;
                    r_sram_oe_n  <= 1'b1;
                    r_sram_we_n  <= (w_state_nxt != S_WR_PULSE);
                    r_sram_be_n  <= w_sel_src;
                    r_sram_dq_oe <= 1'b1;
                    r_sram_dq_o  <= w_data_src;
                end
                S_DONE: begin
                    r_sram_addr  <= w_addr_src;
                    r_sram_ce_n  <= 1'b1;
                    r_sram_oe_n  <= 1'b1;
                    r_sram_we_n  <= 1'b1;
                    r_sram_be_n  <= 4'hF;
                    r_sram_dq_oe <= 1'b0;
                end
                default: begin
                    r_sram_ce_n  <= 1'b1;
                    r_sram_oe_n  <= 1'b1;
                    r_sram_we_n  <= 1'b1;
                    r_sram_be_n  <= 4'hF;
                    r_sram_dq_oe <= 1'b0;
                end
            endcase
        end
    end

    // Stall covers the accepting IDLE cycle through the last busy state
    assign bus.dram_stall = rst_n &&
                            ((r_state == S_IDLE) ? w_req : (r_state != S_DONE));

    assign bus.dram_o_data = r_dram_o_data;
    assign bus.sram_addr   = r_sram_addr;
    assign bus.sram_dq_o   = r_sram_dq_o;
    assign bus.sram_dq_oe  = r_sram_dq_oe;
    assign bus.sram_ce_n   = r_sram_ce_n;
    assign bus.sram_oe_n   = r_sram_oe_n;
    assign bus.sram_we_n   = r_sram_we_n;
    assign bus.sram_be_n   = r_sram_be_n;

endmodule
`default_nettype wire

// File: tb/tb_dram_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dram_ctrl
//  Description : Scoreboard bench for dram_ctrl with a behavioural SRAM and a
//                word-level reference memory.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dram_ctrl;

    localparam int W  = 2;
    localparam int AW = 20;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    dram_ctrl_if #(.SRAM_AW(AW)) bus ();

    dram_ctrl #(.SRAM_AW(AW), .WAIT_CYCLES(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Unwritten words read back a deterministic pattern
    function automatic logic [31:0] init_word(input int a);
        return 32'h1F2E_0000 ^ (a * 32'h0000_9E37);
    endfunction

    // Behavioural asynchronous SRAM
    logic [31:0] sram_mem [int];
    function automatic logic [31:0] sram_rd(input int a);
        return sram_mem.exists(a) ? sram_mem[a] : init_word(a);
    endfunction

    always @(posedge clk) begin : sram_write
        logic [31:0] v;
        if (!bus.sram_ce_n && !bus.sram_we_n && bus.sram_dq_oe) begin
            v = sram_rd(int'(bus.sram_addr));
            for (int i = 0; i < 4; i++)
                if (!bus.sram_be_n[i]) v[8*i +: 8] = bus.sram_dq_o[8*i +: 8];
            sram_mem[int'(bus.sram_addr)] = v;
        end
    end

    always @(negedge clk) begin
        bus.sram_dq_i = (!bus.sram_ce_n && !bus.sram_oe_n) ?
                        sram_rd(int'(bus.sram_addr)) : 32'hBAD0_BAD0;
    end

    // Reference memory: what each word must hold after the writes issued so far
    logic [31:0] ref_mem [int];
    function automatic logic [31:0] ref_rd(input int a);
        return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
    endfunction

    typedef struct {
        bit          is_wr;
        logic [19:0] waddr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [31:0] rdata;
    } exp_t;
    exp_t exp_q[$];

    // ------------------------------------------------------------------ driver
    task automatic issue(input logic en_n, input logic we_n, input logic re_n,
                         input logic [31:0] addr, input logic [31:0] data,
                         input logic [3:0] sel);
        exp_t        e;
        int          w;
        int          k;
        logic [31:0] v;
        bit          acc;
        @(posedge clk); #1;
        w   = int'(addr[21:2]);
        acc = !en_n && (!we_n || !re_n);
        if (acc) begin
            e.is_wr = !we_n;
            e.waddr = addr[21:2];
            e.be    = sel;
            e.wdata = data;
            v = ref_rd(w);
            if (e.is_wr) begin
                for (int i = 0; i < 4; i++)
                    if (!sel[i]) v[8*i +: 8] = data[8*i +: 8];
                ref_mem[w] = v;
            end
            e.rdata = v;
            exp_q.push_back(e);
        end
        bus.dram_en_n       = en_n;
        bus.dram_we_n       = we_n;
        bus.dram_re_n       = re_n;
        bus.mem_dram_o_addr = addr;
        bus.mem_dram_o_data = data;
        bus.mem_sel         = sel;
        if (acc) begin
            for (k = 0; k < 30; k++) begin
                @(negedge clk);
                if (!bus.dram_stall) break;
            end
            if (k == 30) check("handshake_timeout", 32'd0, 32'd1);
        end else begin
            @(negedge clk);
        end
    endtask

    task automatic go_idle(input int n);
        @(posedge clk); #1;
        bus.dram_en_n = 1'b1;
        bus.dram_we_n = 1'b1;
        bus.dram_re_n = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    // ----------------------------------------------------------------- monitor
    exp_t        cur;
    bit          prev_stall = 1'b0;
    logic [31:0] last_rd = 32'h0;
    int sc, n_ce, n_oe, n_we, n_dq, we_first, we_last, oe_first, bus_err;

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall = 1'b0;
            exp_q.delete();
            last_rd = 32'h0;
        end else begin
            if (bus.dram_stall) begin
                if (!prev_stall) begin
                    sc = 0; n_ce = 0; n_oe = 0; n_we = 0; n_dq = 0; bus_err = 0;
                    we_first = -1; we_last = -1; oe_first = -1;
                    if (exp_q.size() == 0) check("unexpected_stall", 32'd1, 32'd0);
                end
                if (exp_q.size() != 0) begin
                    cur = exp_q[0];
                    if (!bus.sram_ce_n) begin
                        n_ce++;
                        if (bus.sram_addr != cur.waddr) bus_err++;
                        if (bus.sram_be_n != (cur.is_wr ? cur.be : 4'h0)) bus_err++;
                        if (cur.is_wr && (!bus.sram_dq_oe || bus.sram_dq_o != cur.wdata)) bus_err++;
                    end
                    if (!bus.sram_oe_n) begin
                        n_oe++;
                        if (oe_first < 0) oe_first = sc;
                    end
                    if (!bus.sram_we_n) begin
                        n_we++;
                        if (we_first < 0) we_first = sc;
                        we_last = sc;
                    end
                    if (bus.sram_dq_oe) n_dq++;
                end
                sc++;
            end else begin
                if (prev_stall && exp_q.size() != 0) begin
                    cur = exp_q.pop_front();
                    check("stall_len",  sc,   cur.is_wr ? W + 3 : W + 1);
                    check("ce_cycles",  n_ce, cur.is_wr ? W + 2 : W);
                    check("oe_cycles",  n_oe, cur.is_wr ? 0 : W);
                    check("we_cycles",  n_we, cur.is_wr ? W : 0);
                    check("dq_oe_cycles", n_dq, cur.is_wr ? W + 2 : 0);
                    check("bus_fields", bus_err, 0);
                    if (cur.is_wr) begin
                        check("we_first", we_first, 2);
                        check("we_last",  we_last,  W + 1);
                    end else begin
                        check("oe_first", oe_first, 1);
                        last_rd = cur.rdata;
                    end
                end
                check("idle_ctrl", {bus.sram_ce_n, bus.sram_oe_n, bus.sram_we_n, bus.sram_dq_oe}, 4'b1110);
            end
            check("load_data", bus.dram_o_data, last_rd);
            prev_stall = bus.dram_stall;
        end
    end

    // ---------------------------------------------------------------- stimulus
    initial begin : stim
        int          k;
        logic [31:0] a;
        logic [31:0] d;
        int          op;

        bus.dram_en_n = 1'b1; bus.dram_we_n = 1'b1; bus.dram_re_n = 1'b1;
        bus.mem_dram_o_addr = '0; bus.mem_dram_o_data = '0; bus.mem_sel = 4'hF;
        bus.sram_dq_i = '0;

        #12;
        check("rst_ctrl", {bus.sram_ce_n, bus.sram_oe_n, bus.sram_we_n, bus.sram_dq_oe}, 4'b1110);
        check("rst_be_n", bus.sram_be_n, 4'hF);
        check("rst_addr", bus.sram_addr, 0);
        check("rst_dq_o", bus.sram_dq_o, 0);
        check("rst_data", bus.dram_o_data, 0);
        check("rst_stall", bus.dram_stall, 0);
        @(posedge clk); #1 rst_n = 1'b1;

        // Word read of a preloaded location
        sram_mem[32'h40] = 32'hDEADBEEF;
        ref_mem[32'h40]  = 32'hDEADBEEF;
        issue(1'b0, 1'b1, 1'b0, 32'h0000_0100, 32'h0, 4'h0);
        // Byte store to lane 3, then read it back
        issue(1'b0, 1'b0, 1'b1, 32'h0000_0103, 32'hA5A5A5A5, 4'b0111);
        issue(1'b0, 1'b1, 1'b0, 32'h0000_0100, 32'h0, 4'h0);
        // Strobes without enable: nothing happens
        issue(1'b1, 1'b0, 1'b1, 32'h0000_0100, 32'h11111111, 4'h0);
        issue(1'b1, 1'b0, 1'b0, 32'h0000_0100, 32'h22222222, 4'h0);
        // Store then load back-to-back
        issue(1'b0, 1'b0, 1'b1, 32'h0000_0010, 32'h12345678, 4'h0);
        issue(1'b0, 1'b1, 1'b0, 32'h0000_0010, 32'h0, 4'h0);
        // Both strobes low is a write
        issue(1'b0, 1'b0, 1'b0, 32'h0000_0020, 32'hCAFEF00D, 4'h0);
        issue(1'b0, 1'b1, 1'b0, 32'h0000_0020, 32'h0, 4'h0);
        // Store with no lanes selected leaves memory unchanged
        issue(1'b0, 1'b0, 1'b1, 32'h0000_0100, 32'h00000000, 4'hF);
        issue(1'b0, 1'b1, 1'b0, 32'h0000_0100, 32'h0, 4'h0);

        // Reset during the write pulse
        issue(1'b1, 1'b1, 1'b1, 32'h0, 32'h0, 4'hF);
        @(posedge clk); #1;
        bus.dram_en_n = 1'b0; bus.dram_we_n = 1'b0; bus.dram_re_n = 1'b1;
        bus.mem_dram_o_addr = 32'h0000_0300; bus.mem_dram_o_data = 32'h5555AAAA;
        bus.mem_sel = 4'h0;
        cur.is_wr = 1'b1; cur.waddr = 20'hC0; cur.be = 4'h0;
        cur.wdata = 32'h5555AAAA; cur.rdata = 32'h0;
        exp_q.push_back(cur);
        for (k = 0; k < 10; k++) begin
            @(negedge clk);
            if (!bus.sram_we_n) break;
        end
        check("we_pulse_seen", bus.sram_we_n, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        check("arst_we_n",  bus.sram_we_n,  1'b1);
        check("arst_dq_oe", bus.sram_dq_oe, 1'b0);
        check("arst_stall", bus.dram_stall, 1'b0);
        check("arst_ce_n",  bus.sram_ce_n,  1'b1);
        bus.dram_en_n = 1'b1; bus.dram_we_n = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        // The aborted word may hold anything; take whatever the SRAM kept
        ref_mem[32'hC0] = sram_rd(32'hC0);
        @(negedge clk);
        check("post_rst_data",  bus.dram_o_data, 32'h0);
        check("post_rst_stall", bus.dram_stall,  1'b0);
        issue(1'b0, 1'b1, 1'b0, 32'h0000_0300, 32'h0, 4'h0);

        // Randomized traffic over a small window so reads hit earlier writes
        for (int n = 0; n < 60; n++) begin
            a = $urandom();
            a[21:2] = 20'h00200 + 20'($urandom_range(0, 15));
            d = $urandom();
            op = $urandom_range(0, 3);
            case (op)
                0: issue(1'b0, 1'b1, 1'b0, a, d, 4'($urandom_range(0, 15)));
                1: issue(1'b0, 1'b0, 1'b1, a, d, 4'($urandom_range(0, 15)));
                2: issue(1'b0, 1'b0, 1'b0, a, d, 4'($urandom_range(0, 15)));
                default: issue(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a, d, 4'h0);
            endcase
        end
        go_idle(4);
        check("queue_drained", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
